tt_um_vstehle_xform_pipe: RTL and testbench
===========================================

// Module: tt_um_vstehle_xform_pipe
// PURPOSE
// - Parametrised successor of the single-cycle tile inverter: a registered, mode-selectable byte
//   transform for the tile slot. Same tile pin set (ui_in/uo_out/uio_*, ena, clk, rst_n).
// - Adds a DEPTH-stage pipeline, an XOR/add accumulator, hold/clear controls and a status nibble.
// - Drives the bidirectional pins split: low nibble = control inputs, high nibble = status outputs.
// PARAMETERS
// - WIDTH  8  data width of ui_in/uo_out (tile build uses 8)
// - DEPTH  2  pipeline stages between ui_in sample and uo_out, legal 1..8
// PORTS
// - clk      in   1      single clock, all state on rising edge
// - rst_n    in   1      reset, asynchronous, active-low
// - ena      in   1      design enable; low = outputs forced 0, state frozen
// - ui_in    in   WIDTH  data input, sampled every advancing cycle
// - uio_in   in   8      [1:0] mode, [2] hold, [3] clear, [7:4] ignored
// - uo_out   out  WIDTH  transformed data, last pipeline stage
// - uio_out  out  8      [7] valid, [6] carry sticky, [5:4] mode tag of uo_out, [3:0] = 0
// - uio_oe   out  8      8'hF0 when ena=1, else 8'h00
// BEHAVIOUR
// - Reset (rst_n=0, async): pipe regs, tags, acc, sticky, fill counter -> 0; uo_out=0, uio_out=0.
// - uio_oe is combinational: 8'hF0 when ena=1, 8'h00 when ena=0.
// - ena=0: uo_out=0, uio_out=0; acc, sticky, pipe frozen; fill counter cleared to 0.
// - Advance = ena & ~hold. Only on advance does the pipe shift and stage0 load.
// - Stage0 result by mode (mode sampled same cycle as ui_in):
//   00: ~ui_in; 01: ui_in; 10: acc ^ ui_in; 11: (acc + ui_in) mod 2^WIDTH.
// - Modes 10/11 on advance: acc <= stage0 result. Mode 11 carry-out sets sticky (stays 1).
// - acc is not touched in modes 00/01; value retained across mode changes.
// - Each stage carries a 2-bit mode tag with its data; uio_out[5:4] = tag of last stage.
// - Latency: ui_in sampled at edge n appears on uo_out after edge n+DEPTH-1 (DEPTH advancing
//   edges total, including the sampling edge). No bubbles unless hold.
// - Mode change mid-stream affects only samples taken after the change; in-flight data unchanged.
// - Fill counter counts advancing cycles, saturates at DEPTH; valid = (count == DEPTH).
// - Hold=1: pipe, tags, acc, fill counter frozen; uo_out stable. No sample lost or duplicated.
// - Clear=1 (sync, needs ena=1): acc <= 0, sticky <= 0. Clear beats hold for acc/sticky.
//   Pipe still obeys hold.
// - Clear and advance together in mode 10/11: stage0 loads 0, acc <= 0, sticky <= 0.
//   Clear does not set sticky.
// - Clear in mode 00/01: pipe advances normally; acc, sticky still cleared.
// - Reset asserted mid-operation: all state and outputs 0 immediately, no clock needed.
//   Valid refills after DEPTH advancing cycles.
// - Adder is WIDTH+1 bits; bit WIDTH is carry-out. No saturation; data wraps.
// TESTING
// - Reset with ena=1 -> uo_out=0, uio_out=0, uio_oe=8'hF0; valid low until DEPTH=2 advancing
//   edges, then 1.
// - Mode 00, DEPTH=2, ui_in=8'h5A at edge n -> uo_out=8'hA5 after edge n+1; uio_out=8'h80
//   (valid, tag 00).
// - Mode 10 after clear, inputs 8'h0F then 8'hFF -> uo_out 8'h0F then 8'hF0, tag 10.
// - Mode 11 after clear, inputs 8'hF0, 8'h20 -> uo_out 8'hF0 then 8'h10.
//   uio_out[6]=1 and stays 1 until clear.
// - Hold for 3 cycles mid-stream of 1,2,3,4 -> uo_out frozen during hold, acc unchanged;
//   sequence resumes 1,2,3,4 with no gap/duplicate.
// - ena low 2 cycles mid-stream -> uo_out=0, uio_oe=0, valid=0; re-enable -> valid after DEPTH
//   edges, acc preserved; async rst_n pulse between edges -> all outputs 0 at once.

Source files
------------

// File: rtl/tt_um_vstehle_xform_pipe.sv
// Registered, mode-selectable byte transform for the tile slot (invert/pass/xor-acc/add-acc).
// Latency: DEPTH advancing edges from ui_in sample to uo_out, including the sampling edge.
// Backpressure: hold (uio_in[2]) freezes pipe/acc/fill count; ena=0 freezes state, zeroes outputs.
//
// Ports:
//   clk, rst_n      single rising-edge clock, asynchronous active-low reset
//   ena             design enable; low forces outputs to 0 and freezes state
//   ui_in           data input, sampled on every advancing edge
//   uio_in          [1:0] mode, [2] hold, [3] clear, [7:4] unused
//   uo_out          last pipeline stage data
//   uio_out         [7] valid, [6] carry sticky, [5:4] mode tag of uo_out, [3:0] zero
//   uio_oe          high nibble driven while enabled
module tt_um_vstehle_xform_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [7:0]       uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]       mode;
    logic             hold;
    logic             clear;
    logic             advance;
    logic             acc_mode;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] stage0;

    logic [WIDTH-1:0] pipe_dat [DEPTH];
    logic [1:0]       pipe_tag [DEPTH];
    logic [WIDTH-1:0] acc;
    logic             sticky;
    logic [CW-1:0]    fill_cnt;
    logic             valid;

    // Upper control nibble has no function.
    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[7:4]};

    assign mode     = uio_in[1:0];
    assign hold     = uio_in[2];
    assign clear    = uio_in[3];
    assign advance  = ena & ~hold;
    assign acc_mode = mode[1];

    // One extra bit so the carry-out of the wrap-around add is visible.
    assign sum = {1'b0, acc} + {1'b0, ui_in};

    always_comb begin
        stage0 = '0;
        unique case (mode)
            2'b00: stage0 = ~ui_in;
            2'b01: stage0 = ui_in;
            2'b10: stage0 = acc ^ ui_in;
            2'b11: stage0 = sum[WIDTH-1:0];
            default: stage0 = '0;
        endcase
        // Clearing in an accumulating mode restarts the stream from zero.
        if (clear && acc_mode) begin
            stage0 = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_dat[i] <= '0;
                pipe_tag[i] <= '0;
            end
            acc      <= '0;
            sticky   <= 1'b0;
            fill_cnt <= '0;
        end else if (ena) begin
            if (advance) begin
                pipe_dat[0] <= stage0;
                pipe_tag[0] <= mode;
                for (int i = 1; i < DEPTH; i++) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                    pipe_tag[i] <= pipe_tag[i-1];
                end
                if (fill_cnt != FULL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
            // Clear wins over hold for the accumulator and sticky flag.
            if (clear) begin
                acc    <= '0;
                sticky <= 1'b0;
            end else if (advance && acc_mode) begin
                acc <= stage0;
                if (mode == 2'b11 && sum[WIDTH]) begin
                    sticky <= 1'b1;
                end
            end
        end else begin
            // Disabling drops validity; the pipe contents themselves are kept.
            fill_cnt <= '0;
        end
    end

    assign valid   = (fill_cnt == FULL);
    assign uo_out  = ena ? pipe_dat[DEPTH-1] : '0;
    assign uio_out = ena ? {valid, sticky, pipe_tag[DEPTH-1], 4'b0000} : 8'h00;
    assign uio_oe  = ena ? 8'hF0 : 8'h00;

endmodule

// File: tb/tb_tt_um_vstehle_xform_pipe.sv
// Testbench for tt_um_vstehle_xform_pipe (WIDTH=8, DEPTH=2): directed vectors with literal
// expectations plus a per-cycle comparison against a queue-based behavioural model.
module tb_tt_um_vstehle_xform_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b1;
    logic [WIDTH-1:0] ui_in = '0;
    logic [7:0]       uio_in = '0;
    logic [WIDTH-1:0] uo_out;
    logic [7:0]       uio_out;
    logic [7:0]       uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    tt_um_vstehle_xform_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial forever #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist holds the last DEPTH produced results {tag, data}; output is the oldest once full.
    logic [9:0] hist[$];
    int         m_acc = 0;
    bit         m_sticky = 0;
    int         m_fill = 0;

    always @(posedge clk or negedge rst_n) begin
        int m, r, s;
        bit h, c;
        if (!rst_n) begin
            hist.delete();
            m_acc = 0;
            m_sticky = 0;
            m_fill = 0;
        end else if (!ena) begin
            m_fill = 0;
        end else begin
            m = int'(uio_in[1:0]);
            h = uio_in[2];
            c = uio_in[3];
            s = m_acc + int'(ui_in);
            if (!h) begin
                case (m)
                    0: r = 255 - int'(ui_in);
                    1: r = int'(ui_in);
                    2: r = m_acc ^ int'(ui_in);
                    default: r = s % 256;
                endcase
                if (c && m >= 2) r = 0;
                hist.push_back({2'(m), 8'(r)});
                if (hist.size() > DEPTH) void'(hist.pop_front());
                if (m_fill < DEPTH) m_fill++;
                if (m >= 2 && !c) begin
                    m_acc = r;
                    if (m == 3 && s > 255) m_sticky = 1;
                end
            end
            if (c) begin
                m_acc = 0;
                m_sticky = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n) begin
            e = (hist.size() == DEPTH) ? hist[0] : 10'h000;
            if (ena) begin
                chk("model uo_out", 32'(uo_out), 32'(e[7:0]));
                chk("model uio_out", 32'(uio_out),
                    32'({(m_fill == DEPTH), m_sticky, e[9:8], 4'b0000}));
                chk("model uio_oe", 32'(uio_oe), 32'h0F0);
            end else begin
                chk("model uo_out dis", 32'(uo_out), 32'h0);
                chk("model uio_out dis", 32'(uio_out), 32'h0);
                chk("model uio_oe dis", 32'(uio_oe), 32'h0);
            end
        end
    end

    // Drive one cycle: inputs settle mid-cycle, outputs are read 1 time unit after the edge.
    task automatic step(input logic [7:0] d, input logic [1:0] m,
                        input logic h = 1'b0, input logic c = 1'b0);
        ui_in  = d;
        uio_in = {4'b0000, c, h, m};
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state with ena=1
        #12;
        chk("reset uo_out", 32'(uo_out), 32'h00);
        chk("reset uio_out", 32'(uio_out), 32'h00);
        chk("reset uio_oe", 32'(uio_oe), 32'hF0);
        rst_n = 1'b1;

        // Mode 00 inversion, latency 2
        step(8'h5A, 2'b00);
        chk("fill1 valid", 32'(uio_out[7]), 32'h0);
        step(8'h00, 2'b00);
        chk("inv uo_out", 32'(uo_out), 32'hA5);
        chk("inv uio_out", 32'(uio_out), 32'h80);

        // Mode 10 after clear: 0F, FF -> 0F, F0
        step(8'h33, 2'b10, 1'b0, 1'b1);
        step(8'h0F, 2'b10);
        step(8'hFF, 2'b10);
        chk("xor first", 32'(uo_out), 32'h0F);
        chk("xor tag", 32'(uio_out), 32'hA0);
        step(8'h00, 2'b01);
        chk("xor second", 32'(uo_out), 32'hF0);

        // Mode 11 after clear: F0, 20 -> F0, 10 with sticky carry
        step(8'h00, 2'b11, 1'b0, 1'b1);
        step(8'hF0, 2'b11);
        step(8'h20, 2'b11);
        chk("add first", 32'(uo_out), 32'hF0);
        chk("add status", 32'(uio_out), 32'hF0);
        step(8'h00, 2'b01);
        chk("add wrap", 32'(uo_out), 32'h10);
        step(8'h00, 2'b01);
        chk("sticky holds", 32'(uio_out), 32'hD0);
        step(8'h00, 2'b01, 1'b0, 1'b1);
        chk("sticky cleared", 32'(uio_out), 32'h90);

        // Hold mid-stream of 1,2,3,4 (acc mode during hold must not touch acc)
        step(8'h01, 2'b01);
        step(8'h02, 2'b01);
        chk("hold pre", 32'(uo_out), 32'h01);
        for (int i = 0; i < 3; i++) begin
            step(8'h77, 2'b10, 1'b1);
            chk("hold frozen", 32'(uo_out), 32'h01);
        end
        step(8'h03, 2'b01);
        chk("resume 2", 32'(uo_out), 32'h02);
        step(8'h04, 2'b01);
        chk("resume 3", 32'(uo_out), 32'h03);
        step(8'h00, 2'b10);
        chk("resume 4", 32'(uo_out), 32'h04);
        step(8'h00, 2'b01);
        chk("acc kept 0", 32'(uo_out), 32'h00);
        chk("acc kept tag", 32'(uio_out), 32'hA0);

        // ena low two cycles, accumulator preserved
        step(8'h3C, 2'b10);
        step(8'h00, 2'b01);
        chk("pre-dis", 32'(uo_out), 32'h3C);
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(8'hAA, 2'b10);
            chk("dis uo_out", 32'(uo_out), 32'h00);
            chk("dis uio_oe", 32'(uio_oe), 32'h00);
            chk("dis uio_out", 32'(uio_out), 32'h00);
        end
        ena = 1'b1;
        step(8'h00, 2'b10);
        chk("re-en not valid", 32'(uio_out[7]), 32'h0);
        step(8'h00, 2'b01);
        chk("re-en acc", 32'(uo_out), 32'h3C);
        chk("re-en status", 32'(uio_out), 32'hA0);

        // Directed mixed pattern exercised through the model compare
        for (int i = 0; i < 24; i++) begin
            step(8'(i * 37 + 11), 2'(i % 4), (i % 5) == 4, (i % 7) == 6);
        end

        // Asynchronous reset pulse between edges
        step(8'hF0, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async uo_out", 32'(uo_out), 32'h00);
        chk("async uio_out", 32'(uio_out), 32'h00);
        chk("async uio_oe", 32'(uio_oe), 32'hF0);
        #1;
        rst_n = 1'b1;
        step(8'h12, 2'b01);
        chk("refill 1", 32'(uio_out[7]), 32'h0);
        step(8'h34, 2'b01);
        chk("refill 2", 32'(uio_out), 32'h90);
        chk("refill data", 32'(uo_out), 32'h12);
        step(8'h00, 2'b01);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
